// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: load-use and branch-compare interlocks,
// redirect flush, and saturating stall/flush event counters.
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic             IF_ID_branch,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_MemRead,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01
  } state_t;

  state_t     st;
  logic [1:0] remain;

  logic       ex_hit;
  logic       mem_hit;
  logic       h1, h2, h3, h4;
  logic [1:0] need;
  logic       in_stall;
  logic       stall;
  logic       flush;

  assign in_stall = (st == STALL);

  // Source match against EX/MEM destinations; r0 never matches
  always_comb begin
    ex_hit  = (ID_EX_rd != 5'd0) &&
              ((ID_EX_rd == IF_ID_rs) ||
               (IF_ID_uses_rt && (ID_EX_rd == IF_ID_rt)));
    mem_hit = (EX_MEM_rd != 5'd0) &&
              ((EX_MEM_rd == IF_ID_rs) ||
               (IF_ID_uses_rt && (EX_MEM_rd == IF_ID_rt)));
  end

  // Hazard classes and resulting stall demand, highest first
  always_comb begin
    h3 = IF_ID_branch && ID_EX_MemRead && ex_hit;
    h2 = IF_ID_branch && ID_EX_RegWrite &&
         !ID_EX_MemRead && ex_hit;
    h4 = IF_ID_branch && EX_MEM_MemRead && mem_hit;
    h1 = !IF_ID_branch && ID_EX_MemRead && ex_hit;
    need = 2'd0;
    priority case (1'b1)
      h3:      need = 2'd2;
      h2:      need = 2'd1;
      h4:      need = 2'd1;
      h1:      need = 2'd1;
      default: need = 2'd0;
    endcase
  end

  // Pipeline control; reset forces free-running, stall beats flush
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!reset) begin
      stall = in_stall || (need != 2'd0);
      flush = !stall && (branch_taken || jump);
    end
    PC_write     = !stall;
    IF_ID_write  = !stall;
    ID_EX_bubble = stall;
    IF_ID_flush  = flush;
  end

  assign state = st;

  // Stall sequencer: a two-cycle demand parks in STALL for one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= RUN;
      remain <= 2'd0;
    end else begin
      case (st)
        RUN: begin
          if (need == 2'd2) begin
            st     <= STALL;
            remain <= 2'd1;
          end
        end
        STALL: begin
          remain <= remain - 2'd1;
          if (remain <= 2'd1) st <= RUN;
        end
        default: begin
          st     <= RUN;
          remain <= 2'd0;
        end
      endcase
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!PC_write && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (IF_ID_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: default-width instance
// plus a 4-bit counter instance sharing the same stimulus.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IF_ID_rs, IF_ID_rt;
  logic        IF_ID_uses_rt, IF_ID_branch;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_RegWrite, ID_EX_MemRead;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_MemRead;
  logic        branch_taken, jump;

  logic        pc_w, ifid_w, bub, fl;
  logic [1:0]  st;
  logic [15:0] sc, fc;

  logic        pc_w4, ifid_w4, bub4, fl4;
  logic [1:0]  st4;
  logic [3:0]  sc4, fc4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .IF_ID_uses_rt(IF_ID_uses_rt),
    .IF_ID_branch(IF_ID_branch),
    .ID_EX_rd(ID_EX_rd),
    .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_MemRead(EX_MEM_MemRead),
    .branch_taken(branch_taken), .jump(jump),
    .PC_write(pc_w), .IF_ID_write(ifid_w),
    .ID_EX_bubble(bub), .IF_ID_flush(fl),
    .state(st), .stall_count(sc), .flush_count(fc)
  );

  hazard_stall_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .IF_ID_uses_rt(IF_ID_uses_rt),
    .IF_ID_branch(IF_ID_branch),
    .ID_EX_rd(ID_EX_rd),
    .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_MemRead(EX_MEM_MemRead),
    .branch_taken(branch_taken), .jump(jump),
    .PC_write(pc_w4), .IF_ID_write(ifid_w4),
    .ID_EX_bubble(bub4), .IF_ID_flush(fl4),
    .state(st4), .stall_count(sc4), .flush_count(fc4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // comb outputs: pc_write, if_id_write, bubble, flush
  task automatic chk_ctl(input string tag, input logic p,
                         input logic w, input logic b,
                         input logic f);
    chk({tag, ".pc_write"}, 32'(pc_w), 32'(p));
    chk({tag, ".if_id_write"}, 32'(ifid_w), 32'(w));
    chk({tag, ".bubble"}, 32'(bub), 32'(b));
    chk({tag, ".flush"}, 32'(fl), 32'(f));
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] s,
                         input int scnt, input int fcnt);
    chk({tag, ".state"}, 32'(st), 32'(s));
    chk({tag, ".stall_count"}, 32'(sc), scnt);
    chk({tag, ".flush_count"}, 32'(fc), fcnt);
  endtask

  task automatic clear_in();
    IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
    IF_ID_uses_rt = 1'b0; IF_ID_branch = 1'b0;
    ID_EX_rd = 5'd0; ID_EX_RegWrite = 1'b0;
    ID_EX_MemRead = 1'b0; EX_MEM_rd = 5'd0;
    EX_MEM_MemRead = 1'b0; branch_taken = 1'b0;
    jump = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] r);
    clear_in();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1;
    ID_EX_rd = r; IF_ID_rs = r;
  endtask

  task automatic h3_vec();
    clear_in();
    IF_ID_branch = 1'b1; IF_ID_rt = 5'd9;
    IF_ID_uses_rt = 1'b1; IF_ID_rs = 5'd2;
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1;
    ID_EX_rd = 5'd9;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic next_drive();
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    reset = 1'b1;

    // reset with a live hazard and redirect present
    next_drive();
    load_use(5'd8); branch_taken = 1'b1;
    #1 chk_ctl("reset_out", 1, 1, 0, 0);
    edge_sample();
    chk_reg("reset_reg", 2'b00, 0, 0);

    // idle
    next_drive();
    reset = 1'b0; clear_in();
    #1 chk_ctl("idle", 1, 1, 0, 0);
    edge_sample();
    chk_reg("idle_reg", 2'b00, 0, 0);

    // load-use: one bubble
    next_drive();
    load_use(5'd8);
    #1 chk_ctl("h1", 0, 0, 1, 0);
    edge_sample();
    chk_reg("h1_reg", 2'b00, 1, 0);
    next_drive();
    clear_in();
    #1 chk_ctl("h1_after", 1, 1, 0, 0);
    edge_sample();
    chk_reg("h1_after_reg", 2'b00, 1, 0);

    // register zero never hazards
    next_drive();
    load_use(5'd0);
    #1 chk_ctl("r0", 1, 1, 0, 0);
    edge_sample();
    chk("r0.stall_count", 32'(sc), 1);

    // rt match ignored when rt unused
    next_drive();
    clear_in();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5;
    IF_ID_rt = 5'd5; IF_ID_rs = 5'd3;
    #1 chk("rt_unused.pc_write", 32'(pc_w), 1);
    edge_sample();

    // branch after load: two stall cycles, taken ignored
    next_drive();
    h3_vec(); branch_taken = 1'b1;
    #1 chk_ctl("h3_c1", 0, 0, 1, 0);
    edge_sample();
    chk_reg("h3_c1_reg", 2'b01, 2, 0);
    next_drive();
    clear_in(); branch_taken = 1'b1;
    #1 chk_ctl("h3_c2", 0, 0, 1, 0);
    edge_sample();
    chk_reg("h3_c2_reg", 2'b00, 3, 0);
    next_drive();
    clear_in();
    #1 chk_ctl("h3_done", 1, 1, 0, 0);
    edge_sample();
    chk_reg("h3_done_reg", 2'b00, 3, 0);

    // branch after ALU op: one stall
    next_drive();
    clear_in();
    IF_ID_branch = 1'b1; IF_ID_rs = 5'd4;
    ID_EX_RegWrite = 1'b1; ID_EX_rd = 5'd4;
    #1 chk("h2.pc_write", 32'(pc_w), 0);
    edge_sample();
    chk_reg("h2_reg", 2'b00, 4, 0);

    // branch after load in MEM: one stall
    next_drive();
    clear_in();
    IF_ID_branch = 1'b1; IF_ID_rt = 5'd6;
    IF_ID_uses_rt = 1'b1;
    EX_MEM_MemRead = 1'b1; EX_MEM_rd = 5'd6;
    #1 chk("h4.bubble", 32'(bub), 1);
    edge_sample();
    chk_reg("h4_reg", 2'b00, 5, 0);

    // MEM load does not stall a non-branch
    next_drive();
    IF_ID_branch = 1'b0;
    #1 chk("mem_nb.pc_write", 32'(pc_w), 1);
    edge_sample();
    chk("mem_nb.stall_count", 32'(sc), 5);

    // stall beats flush, then flush next cycle
    next_drive();
    load_use(5'd12); branch_taken = 1'b1;
    #1 chk_ctl("sim_c1", 0, 0, 1, 0);
    edge_sample();
    chk_reg("sim_c1_reg", 2'b00, 6, 0);
    next_drive();
    clear_in(); branch_taken = 1'b1;
    #1 chk_ctl("sim_c2", 1, 1, 0, 1);
    edge_sample();
    chk_reg("sim_c2_reg", 2'b00, 6, 1);
    next_drive();
    clear_in(); jump = 1'b1;
    #1 chk("jump.flush", 32'(fl), 1);
    edge_sample();
    chk("jump.flush_count", 32'(fc), 2);

    // reset during STALL
    next_drive();
    h3_vec();
    edge_sample();
    chk_reg("rst_stall_pre", 2'b01, 7, 2);
    next_drive();
    clear_in(); reset = 1'b1; jump = 1'b1;
    #1 chk_ctl("rst_in_stall", 1, 1, 0, 0);
    edge_sample();
    chk_reg("rst_stall_reg", 2'b00, 0, 0);
    chk("rst_stall.sc4", 32'(sc4), 0);
    next_drive();
    reset = 1'b0; clear_in();
    #1 chk_ctl("post_rst", 1, 1, 0, 0);
    edge_sample();
    chk_reg("post_rst_reg", 2'b00, 0, 0);

    // normal detection right after reset, then saturation
    next_drive();
    load_use(5'd8);
    #1 chk("post_rst_h1.pc_write", 32'(pc_w), 0);
    edge_sample();
    chk("post_rst_h1.stall_count", 32'(sc), 1);
    for (int i = 1; i < 20; i++) begin
      next_drive();
      load_use(5'(i % 31 + 1));
      edge_sample();
    end
    chk("sat.sc4", 32'(sc4), 15);
    chk("sat.sc16", 32'(sc), 20);
    chk("sat.state4", 32'(st4), 0);
    next_drive();
    clear_in();
    #1 chk("sat_end.pc_write4", 32'(pc_w4), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
